// File: rtl/clock_time_ctrl.sv
// ---------------------------------------------------------------------------
// clock_time_ctrl
//   Timekeeping and time-setting controller for an 8-digit HH:MM:SS display.
//   Holds the time as BCD fields, advances them on a 1 Hz tick in RUN, and
//   lets the user edit one field at a time through a 4-state set-mode FSM.
//   The field being edited blinks at BLINK_HZ.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   tick_1hz     : one-cycle pulse per second (clk domain)
//   key_mode_n   : debounced mode key level, 0 = pressed
//   key_up_n     : debounced increment key level, 0 = pressed
//   key_dn_n     : debounced decrement key level, 0 = pressed
//   hh_bcd       : hours   {tens, ones}, 00..23
//   mm_bcd       : minutes {tens, ones}, 00..59
//   ss_bcd       : seconds {tens, ones}, 00..59
//   blank        : per-digit dark mask, [5:4]=HH [3:2]=MM [1:0]=SS
//   mode         : FSM state, 0 RUN, 1 SET_HH, 2 SET_MM, 3 SET_SS
//   led          : one-hot copy of mode
//
// Key handshake: a key is acted on once, in the cycle its level is first
// sampled low after having been high; holding it produces nothing more.
// ---------------------------------------------------------------------------
module clock_time_ctrl #(
    parameter int F_CLK    = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic [5:0] blank,
    output logic [1:0] mode,
    output logic [3:0] led
);

    localparam int BLINK_DIV = F_CLK / (2 * BLINK_HZ);
    localparam int CW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SET_HH = 2'd1,
        S_SET_MM = 2'd2,
        S_SET_SS = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    hh_q, hh_d;
    logic [7:0]    mm_q, mm_d;
    logic [7:0]    ss_q, ss_d;
    logic [5:0]    blank_q, blank_d;
    logic [3:0]    led_q, led_d;
    logic [2:0]    prev_q, prev_d;     // {mode, up, dn} levels of last cycle
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    logic press_mode, press_up, press_dn;
    logic step_up, step_dn;

    // BCD increment with wrap to 00 once the full field value reaches max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // BCD decrement with wrap from 00 to max_v.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == 8'h00)
            r = max_v;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        blank_d = 6'b000000;
        prev_d  = {key_mode_n, key_up_n, key_dn_n};

        press_mode = prev_q[2] & ~key_mode_n;
        press_up   = prev_q[1] & ~key_up_n;
        press_dn   = prev_q[0] & ~key_dn_n;

        // A mode press swallows up/down; up and down together cancel.
        step_up = press_up & ~press_dn & ~press_mode;
        step_dn = press_dn & ~press_up & ~press_mode;

        case (state_q)
            S_RUN: begin
                // Tick is honoured even when mode is pressed in the same cycle.
                if (tick_1hz) begin
                    ss_d = bcd_inc(ss_q, 8'h59);
                    if (ss_q == 8'h59) begin
                        mm_d = bcd_inc(mm_q, 8'h59);
                        if (mm_q == 8'h59)
                            hh_d = bcd_inc(hh_q, 8'h23);
                    end
                end
            end
            S_SET_HH: begin
                if (step_up)      hh_d = bcd_inc(hh_q, 8'h23);
                else if (step_dn) hh_d = bcd_dec(hh_q, 8'h23);
            end
            S_SET_MM: begin
                if (step_up)      mm_d = bcd_inc(mm_q, 8'h59);
                else if (step_dn) mm_d = bcd_dec(mm_q, 8'h59);
            end
            default: begin // S_SET_SS
                if (step_up)      ss_d = bcd_inc(ss_q, 8'h59);
                else if (step_dn) ss_d = bcd_dec(ss_q, 8'h59);
            end
        endcase

        if (press_mode) begin
            case (state_q)
                S_RUN:    state_d = S_SET_HH;
                S_SET_HH: state_d = S_SET_MM;
                S_SET_MM: state_d = S_SET_SS;
                default:  state_d = S_RUN;
            endcase
        end

        // Blink timer: restarts on any user action so the edited field shows
        // immediately; parked at zero whenever the clock is running.
        if (state_d == S_RUN || press_mode || step_up || step_dn) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end

        case (state_d)
            S_SET_HH: blank_d = {phase_d, phase_d, 4'b0000};
            S_SET_MM: blank_d = {2'b00, phase_d, phase_d, 2'b00};
            S_SET_SS: blank_d = {4'b0000, phase_d, phase_d};
            default:  blank_d = 6'b000000;
        endcase

        led_d = 4'b0001 << state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            hh_q    <= 8'h00;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            blank_q <= 6'b000000;
            led_q   <= 4'b0001;
            prev_q  <= 3'b111;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            blank_q <= blank_d;
            led_q   <= led_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign hh_bcd = hh_q;
    assign mm_bcd = mm_q;
    assign ss_bcd = ss_q;
    assign blank  = blank_q;
    assign mode   = state_q;
    assign led    = led_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
`timescale 1ns/1ps
module tb_clock_time_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       key_mode_n;
    logic       key_up_n;
    logic       key_dn_n;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic [5:0] blank;
    logic [1:0] mode;
    logic [3:0] led;

    clock_time_ctrl #(.F_CLK(100), .BLINK_HZ(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .key_mode_n (key_mode_n),
        .key_up_n   (key_up_n),
        .key_dn_n   (key_dn_n),
        .hh_bcd     (hh_bcd),
        .mm_bcd     (mm_bcd),
        .ss_bcd     (ss_bcd),
        .blank      (blank),
        .mode       (mode),
        .led        (led)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {hh, mm, ss, blank, mode, led}
    logic [35:0] exp_q[$];
    string       name_q[$];
    logic        chk_req;
    int          n_cmp;
    int          n_bad;

    // monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (chk_req) begin
            logic [35:0] act;
            logic [35:0] exp;
            string       nm;
            act = {hh_bcd, mm_bcd, ss_bcd, blank, mode, led};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL no_expectation: got %h", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h:%h:%h blank=%b mode=%0d led=%b, want %h:%h:%h blank=%b mode=%0d led=%b",
                             nm, act[35:28], act[27:20], act[19:12], act[11:6], act[5:4], act[3:0],
                             exp[35:28], exp[27:20], exp[19:12], exp[11:6], exp[5:4], exp[3:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_keys(input logic m, input logic u, input logic d);
        key_mode_n = ~m;
        key_up_n   = ~u;
        key_dn_n   = ~d;
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        set_keys(m, u, d);
        step();
        set_keys(1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic press_n(input logic m, input logic u, input logic d, input int n);
        for (int i = 0; i < n; i++) press(m, u, d);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    // Push the expected outputs, then hand the check to the monitor at the
    // next falling edge (no rising edge happens in between).
    task automatic expect_out(input string nm, input logic [7:0] hh, input logic [7:0] mm,
                              input logic [7:0] ss, input logic [5:0] bl, input logic [1:0] md);
        logic [3:0] ld;
        ld = 4'b0001 << md;
        exp_q.push_back({hh, mm, ss, bl, md, ld});
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        chk_req  = 1'b0;
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        set_keys(1'b0, 1'b0, 1'b0);

        step_n(3);
        expect_out("reset_values", 8'h00, 8'h00, 8'h00, 6'b000000, 2'd0);
        rst_n = 1'b1;
        step();

        // 3661 seconds = 1 h 1 min 1 s
        tick_n(3661);
        expect_out("run_3661_ticks", 8'h01, 8'h01, 8'h01, 6'b000000, 2'd0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        expect_out("reset_again", 8'h00, 8'h00, 8'h00, 6'b000000, 2'd0);

        // set hours: 00 - 1 wraps to 23
        press(1'b1, 1'b0, 1'b0);
        expect_out("enter_set_hh", 8'h00, 8'h00, 8'h00, 6'b000000, 2'd1);
        press(1'b0, 1'b0, 1'b1);
        expect_out("hh_dn_wrap", 8'h23, 8'h00, 8'h00, 6'b000000, 2'd1);

        // set minutes: +1, then +59 wraps back, borrow/carry across tens
        press(1'b1, 1'b0, 1'b0);
        expect_out("enter_set_mm", 8'h23, 8'h00, 8'h00, 6'b000000, 2'd2);
        press(1'b0, 1'b1, 1'b0);
        expect_out("mm_up_1", 8'h23, 8'h01, 8'h00, 6'b000000, 2'd2);
        press_n(1'b0, 1'b1, 1'b0, 59);
        expect_out("mm_up_60_wrap", 8'h23, 8'h00, 8'h00, 6'b000000, 2'd2);
        press(1'b0, 1'b0, 1'b1);
        expect_out("mm_dn_wrap", 8'h23, 8'h59, 8'h00, 6'b000000, 2'd2);
        press_n(1'b0, 1'b0, 1'b1, 10);
        expect_out("mm_dn_borrow", 8'h23, 8'h49, 8'h00, 6'b000000, 2'd2);
        press_n(1'b0, 1'b1, 1'b0, 10);
        expect_out("mm_up_carry", 8'h23, 8'h59, 8'h00, 6'b000000, 2'd2);

        // set seconds to 58
        press(1'b1, 1'b0, 1'b0);
        press_n(1'b0, 1'b0, 1'b1, 2);
        expect_out("ss_set_58", 8'h23, 8'h59, 8'h58, 6'b000000, 2'd3);

        // ticks frozen in SET_SS; 6 edges past counter=1 -> one toggle
        tick_n(3);
        expect_out("ss_frozen", 8'h23, 8'h59, 8'h58, 6'b000011, 2'd3);

        // mode + up + tick together leaving SET_SS: only mode acts
        tick_1hz = 1'b1;
        set_keys(1'b1, 1'b1, 1'b0);
        step();
        tick_1hz = 1'b0;
        set_keys(1'b0, 1'b0, 1'b0);
        step();
        expect_out("mode_beats_up", 8'h23, 8'h59, 8'h58, 6'b000000, 2'd0);

        tick_n(1);
        expect_out("run_to_235959", 8'h23, 8'h59, 8'h59, 6'b000000, 2'd0);
        tick_n(1);
        expect_out("run_midnight", 8'h00, 8'h00, 8'h00, 6'b000000, 2'd0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        expect_out("run_ignores_keys", 8'h00, 8'h00, 8'h00, 6'b000000, 2'd0);

        // tick + mode in RUN: tick applied, then SET_HH
        tick_1hz = 1'b1;
        set_keys(1'b1, 1'b0, 1'b0);
        step();
        tick_1hz = 1'b0;
        set_keys(1'b0, 1'b0, 1'b0);
        step();
        expect_out("tick_and_mode", 8'h00, 8'h00, 8'h01, 6'b000000, 2'd1);
        press(1'b0, 1'b1, 1'b1);
        expect_out("up_dn_cancel", 8'h00, 8'h00, 8'h01, 6'b000000, 2'd1);

        // blink in SET_MM with BLINK_DIV = 5: counter is 1 after press()
        press(1'b1, 1'b0, 1'b0);
        expect_out("blink_start", 8'h00, 8'h00, 8'h01, 6'b000000, 2'd2);
        step_n(3);
        expect_out("blink_before_toggle", 8'h00, 8'h00, 8'h01, 6'b000000, 2'd2);
        step();
        expect_out("blink_dark", 8'h00, 8'h00, 8'h01, 6'b001100, 2'd2);
        step_n(4);
        expect_out("blink_still_dark", 8'h00, 8'h00, 8'h01, 6'b001100, 2'd2);
        step();
        expect_out("blink_lit", 8'h00, 8'h00, 8'h01, 6'b000000, 2'd2);
        step_n(5);
        expect_out("blink_dark_2", 8'h00, 8'h00, 8'h01, 6'b001100, 2'd2);
        set_keys(1'b0, 1'b1, 1'b0);
        step();
        expect_out("up_clears_blink", 8'h00, 8'h01, 8'h01, 6'b000000, 2'd2);
        set_keys(1'b0, 1'b0, 1'b0);
        step();

        // back round to SET_HH, hold up for 1000 cycles: one increment.
        // After the press edge 999 more edges -> 199 toggles -> dark.
        press_n(1'b1, 1'b0, 1'b0, 3);
        expect_out("back_to_set_hh", 8'h00, 8'h01, 8'h01, 6'b000000, 2'd1);
        set_keys(1'b0, 1'b1, 1'b0);
        step_n(1000);
        expect_out("hold_up_once", 8'h01, 8'h01, 8'h01, 6'b110000, 2'd1);
        set_keys(1'b0, 1'b0, 1'b0);
        step();

        press(1'b0, 1'b1, 1'b0);
        expect_out("hh_up_again", 8'h02, 8'h01, 8'h01, 6'b000000, 2'd1);

        // asynchronous reset mid-edit: no rising edge before the check
        rst_n = 1'b0;
        expect_out("async_reset", 8'h00, 8'h00, 8'h00, 6'b000000, 2'd0);
        step();
        rst_n = 1'b1;
        step_n(2);
        expect_out("after_reset", 8'h00, 8'h00, 8'h00, 6'b000000, 2'd0);

        step_n(2);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL unchecked_expectations: got %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and time-setting controller for the 8-digit HH:MM:SS clock display.
- Consumes debounced key levels and a 1 Hz tick. Owns the BCD time registers and a 4-state set-mode FSM.
- Drives the per-digit values and blink-blank mask to the scan/decoder path.
- Replaces the flat seconds counter with directly settable BCD fields.

Parameters:
- F_CLK, 50000000, system clock frequency in Hz.
- BLINK_HZ, 2, blink toggle rate of the field being edited. Half-period is BLINK_DIV = F_CLK/(2*BLINK_HZ) clocks.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick_1hz  input  1  single-cycle pulse, once per second, synchronous to clk.
- key_mode_n  input  1  debounced mode key level, 0 = pressed.
- key_up_n  input  1  debounced increment key level, 0 = pressed.
- key_dn_n  input  1  debounced decrement key level, 0 = pressed.
- hh_bcd  output  8  hours, {tens, ones} BCD, 00..23.
- mm_bcd  output  8  minutes, {tens, ones} BCD, 00..59.
- ss_bcd  output  8  seconds, {tens, ones} BCD, 00..59.
- blank  output  6  per-digit blank mask, 1 = digit dark. [5:4]=HH, [3:2]=MM, [1:0]=SS.
- mode  output  2  current state: 0 RUN, 1 SET_HH, 2 SET_MM, 3 SET_SS.
- led  output  4  one-hot state indicator: led[mode]=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - hh/mm/ss = 00:00:00, mode = RUN, blank = 0, led = 4'b0001.
  - Key history registers = 1 (released), blink counter = 0, blink_phase = 0.
- Key press detection:
  - press_x = prev_x & ~key_x_n, where prev_x is last cycle's key_x_n.
  - One press per falling edge. Holding a key produces no repeats.
  - Effect is visible on outputs the clock edge after the first low sample (1-cycle latency).
- FSM transitions:
  - Mode press advances RUN -> SET_HH -> SET_MM -> SET_SS -> RUN.
  - No other transitions exist.
- RUN state:
  - tick_1hz increments ss. ss 59 -> 00 carries into mm. mm 59 -> 00 carries into hh. hh 23 -> 00.
  - 23:59:59 + tick -> 00:00:00.
  - up/down presses are ignored.
- SET_xx states:
  - tick_1hz is ignored; time is frozen.
  - up increments the selected field only, wrapping 23 -> 00 (HH) or 59 -> 00 (MM/SS).
  - down decrements the selected field only, wrapping 00 -> 23 (HH) or 00 -> 59 (MM/SS).
  - No carry into adjacent fields.
- BCD arithmetic: ones digit wraps 9 -> 0 with tens +1, and 0 -> 9 with tens -1 on decrement. Field limits are checked on the full BCD value.
- Simultaneous events, same cycle:
  - mode + up/down: mode wins, up/down discarded.
  - up + down: no change.
  - tick_1hz + mode press in RUN: the tick is applied, then the state changes.
  - tick in the cycle SET_SS -> RUN: ignored.
- Blink:
  - In SET states the counter runs and blink_phase toggles every BLINK_DIV clocks.
  - blank bits of the selected field = blink_phase; all other bits = 0.
  - Counter and phase clear to 0 on every mode press and every accepted up/down press, so the edited field is lit immediately.
  - In RUN: counter held at 0 and blank = 0.
- Reset mid-operation: immediate return to reset values. No partial edits are retained.
- All outputs are registered; none come from combinational paths off the inputs.

Test Plan:
- Reset, then apply 3661 tick_1hz pulses -> outputs 01:01:01, mode 0, led 0001, blank 000000.
- Preload to 23:59:58 via set mode, return to RUN, apply 2 ticks -> 23:59:59 then 00:00:00.
- Mode press once, down press once -> mode 1, led 0010, hh 23. Mode press, up press x60 -> mm unchanged, wraps back to original value.
- In SET_MM, wait 2*BLINK_DIV clocks with F_CLK=100, BLINK_HZ=10 (BLINK_DIV=5) -> blank toggles 001100/000000 every 5 clocks. An up press clears blank to 000000 next cycle.
- In SET_SS, apply tick_1hz pulses -> ss frozen. Assert mode and up in the same cycle -> mode 0, ss unchanged. Assert up and down together in SET_HH -> hh unchanged.
- Hold key_up_n low for 1000 cycles in SET_HH -> hh increments exactly once. Assert rst_n low mid-edit -> 00:00:00, mode 0 asynchronously.
